// File: rtl/colparity_controller.sv
// Control FSM for the column-parity datapath: loads Count slices, runs one parity pass per
// slice, streams the results out, then pulses done.
module colparity_controller #(
  parameter int unsigned Count = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic inValid,
  output logic inReady,
  input  logic outReady,
  output logic outValid,
  output logic busy,
  output logic done,
  input  logic sliceCntCo,
  input  logic matCntCo,
  input  logic colCntCo,
  output logic adrSrc,
  output logic regSrc,
  output logic sliceCntEn,
  output logic sliceCntClr,
  output logic memRead,
  output logic memWrite,
  output logic regLd,
  output logic regClr,
  output logic regShfR,
  output logic xorSrc,
  output logic matCntEn,
  output logic matCntClr,
  output logic colCntEn,
  output logic colCntClr,
  output logic colRegShR,
  output logic colRegClr,
  output logic PDParLd,
  output logic PDParClr
);

  // The slice counter carry-out lives in the datapath; Count only has to be sane here.
  if (Count < 2) begin : gen_count_check
    $error("colparity_controller: Count must be at least 2");
  end

  localparam logic [3:0] StIdle = 4'd0;
  localparam logic [3:0] StInit = 4'd1;
  localparam logic [3:0] StLdIn = 4'd2;
  localparam logic [3:0] StLdWr = 4'd3;
  localparam logic [3:0] StCRd  = 4'd4;
  localparam logic [3:0] StCShf = 4'd5;
  localparam logic [3:0] StCPar = 4'd6;
  localparam logic [3:0] StCWr  = 4'd7;
  localparam logic [3:0] StOut  = 4'd8;
  localparam logic [3:0] StDone = 4'd9;

  logic [3:0] state_q, state_d;
  logic       first_slice_q, first_slice_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      first_slice_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      first_slice_q <= first_slice_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    first_slice_d = first_slice_q;
    inReady       = 1'b0;
    outValid      = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    adrSrc        = 1'b0;
    regSrc        = 1'b0;
    sliceCntEn    = 1'b0;
    sliceCntClr   = 1'b0;
    memRead       = 1'b0;
    memWrite      = 1'b0;
    regLd         = 1'b0;
    regClr        = 1'b0;
    regShfR       = 1'b0;
    xorSrc        = 1'b0;
    matCntEn      = 1'b0;
    matCntClr     = 1'b0;
    colCntEn      = 1'b0;
    colCntClr     = 1'b0;
    colRegShR     = 1'b0;
    colRegClr     = 1'b0;
    PDParLd       = 1'b0;
    PDParClr      = 1'b0;

    case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) state_d = StInit;
      end
      StInit: begin
        sliceCntClr   = 1'b1;
        matCntClr     = 1'b1;
        colCntClr     = 1'b1;
        colRegClr     = 1'b1;
        PDParClr      = 1'b1;
        regClr        = 1'b1;
        first_slice_d = 1'b1;
        state_d       = StLdIn;
      end
      StLdIn: begin
        inReady = 1'b1;
        if (inValid) begin
          regLd   = 1'b1;
          state_d = StLdWr;
        end
      end
      StLdWr: begin
        memWrite   = 1'b1;
        sliceCntEn = 1'b1;
        state_d    = sliceCntCo ? StCRd : StLdIn;
      end
      StCRd: begin
        memRead = 1'b1;
        regSrc  = 1'b1;
        regLd   = 1'b1;
        state_d = StCShf;
      end
      StCShf: begin
        regShfR   = 1'b1;
        matCntEn  = 1'b1;
        colCntEn  = 1'b1;
        xorSrc    = first_slice_q;
        // Column register shifts in the same cycle the column counter reaches its last bit.
        colRegShR = colCntCo;
        if (matCntCo) state_d = StCPar;
      end
      StCPar: begin
        PDParLd       = 1'b1;
        first_slice_d = 1'b0;
        state_d       = StCWr;
      end
      StCWr: begin
        memWrite   = 1'b1;
        sliceCntEn = 1'b1;
        state_d    = sliceCntCo ? StOut : StCRd;
      end
      StOut: begin
        memRead  = 1'b1;
        outValid = 1'b1;
        if (outReady) begin
          sliceCntEn = 1'b1;
          if (sliceCntCo) state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        busy    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_colparity_controller.sv
// Directed bench for colparity_controller with a behavioural model of the datapath counters.
module tb_colparity_controller;

  localparam int Count = 64;

  logic clk = 1'b0;
  logic rst, start, inValid, outReady;
  logic sliceCntCo, matCntCo, colCntCo;
  logic inReady, outValid, busy, done, adrSrc, regSrc, sliceCntEn, sliceCntClr;
  logic memRead, memWrite, regLd, regClr, regShfR, xorSrc, matCntEn, matCntClr;
  logic colCntEn, colCntClr, colRegShR, colRegClr, PDParLd, PDParClr;

  always #5 clk = ~clk;

  colparity_controller #(.Count(Count)) dut (
    .clk(clk), .rst(rst), .start(start), .inValid(inValid), .inReady(inReady),
    .outReady(outReady), .outValid(outValid), .busy(busy), .done(done),
    .sliceCntCo(sliceCntCo), .matCntCo(matCntCo), .colCntCo(colCntCo),
    .adrSrc(adrSrc), .regSrc(regSrc), .sliceCntEn(sliceCntEn), .sliceCntClr(sliceCntClr),
    .memRead(memRead), .memWrite(memWrite), .regLd(regLd), .regClr(regClr),
    .regShfR(regShfR), .xorSrc(xorSrc), .matCntEn(matCntEn), .matCntClr(matCntClr),
    .colCntEn(colCntEn), .colCntClr(colCntClr), .colRegShR(colRegShR),
    .colRegClr(colRegClr), .PDParLd(PDParLd), .PDParClr(PDParClr)
  );

  // Datapath counters: slice mod Count, parity bit mod 25, column bit mod 5.
  int sc_q, mc_q, cc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q <= 0;
      mc_q <= 0;
      cc_q <= 0;
    end else begin
      if (sliceCntClr) sc_q <= 0;
      else if (sliceCntEn) sc_q <= (sc_q == Count - 1) ? 0 : sc_q + 1;
      if (matCntClr) mc_q <= 0;
      else if (matCntEn) mc_q <= (mc_q == 24) ? 0 : mc_q + 1;
      if (colCntClr) cc_q <= 0;
      else if (colCntEn) cc_q <= (cc_q == 4) ? 0 : cc_q + 1;
    end
  end
  assign sliceCntCo = (sc_q == Count - 1);
  assign matCntCo   = (mc_q == 24);
  assign colCntCo   = (cc_q == 4);

  int n_tests = 0;
  int n_fail  = 0;

  int busy_cyc, inrdy_cyc, outv_cyc, memw_cyc, memr_cyc, scen_cyc, shf_cyc, par_cyc;
  int xor_cyc, colsh_cyc, done_cyc, viol, seq_err, in_acc, out_acc, comp_done, cphase, shf;
  logic prev_ostall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    busy_cyc = 0; inrdy_cyc = 0; outv_cyc = 0; memw_cyc = 0; memr_cyc = 0; scen_cyc = 0;
    shf_cyc = 0; par_cyc = 0; xor_cyc = 0; colsh_cyc = 0; done_cyc = 0; viol = 0;
    seq_err = 0; in_acc = 0; out_acc = 0; comp_done = 0; cphase = 0; shf = 0;
    prev_ostall = 1'b0;
  endtask

  task automatic sample();
    busy_cyc  += int'(busy);
    inrdy_cyc += int'(inReady);
    outv_cyc  += int'(outValid);
    memw_cyc  += int'(memWrite);
    memr_cyc  += int'(memRead);
    scen_cyc  += int'(sliceCntEn);
    shf_cyc   += int'(regShfR);
    par_cyc   += int'(PDParLd);
    colsh_cyc += int'(colRegShR);
    done_cyc  += int'(done);
    if (xorSrc && regShfR) xor_cyc++;
    if (int'(regLd) + int'(regShfR) + int'(regClr) > 1) viol++;
    if (memRead && memWrite) viol++;
    if (adrSrc) viol++;
    if (colRegShR !== (regShfR && colCntCo)) viol++;
    if (inReady && !inValid && (regLd || memWrite)) viol++;
    if (outValid && !outReady && sliceCntEn) viol++;
    if (prev_ostall && !outValid) viol++;
    prev_ostall = outValid && !outReady;
    if (xorSrc && (!regShfR || comp_done != 0)) seq_err++;
    // Compute phase order: regLd(regSrc) -> 25 shifts -> PDParLd -> memWrite.
    if (regLd && regSrc) begin
      if (cphase != 0) seq_err++;
      cphase = 1; shf = 0;
    end
    if (regShfR) begin
      if (cphase != 1 && cphase != 2) seq_err++;
      cphase = 2; shf++;
    end
    if (PDParLd) begin
      if (cphase != 2 || shf != 25) seq_err++;
      cphase = 3;
    end
    if (memWrite) begin
      if (cphase == 3) begin
        cphase = 0; comp_done++;
      end else if (cphase != 0) seq_err++;
    end
    if (inReady && inValid) in_acc++;
    if (outValid && outReady) out_acc++;
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  // One complete run; stall parameters of -1 disable that stall.
  task automatic run(input int sin, input int slen, input int sout, input int olen,
                     input int spulse);
    int sctr, octr, guard;
    clear_stats();
    sctr = 0; octr = 0; guard = 0;
    start = 1'b1; inValid = 1'b1; outReady = 1'b1;
    step();
    start = 1'b0;
    while (done_cyc == 0 && guard < 5000) begin
      if (inReady && in_acc == sin && sctr < slen) begin
        inValid = 1'b0; sctr++;
      end else inValid = 1'b1;
      if (outValid && out_acc == sout && octr < olen) begin
        outReady = 1'b0; octr++;
      end else outReady = 1'b1;
      start = (busy_cyc == spulse);
      step();
      guard++;
    end
    start = 1'b0; inValid = 1'b0; outReady = 1'b0;
  endtask

  task automatic check_run(input string tag, input int exp_busy, input int exp_inrdy,
                           input int exp_outv);
    chk({tag, ".done_seen"}, done_cyc, 1);
    chk({tag, ".busy_cycles"}, busy_cyc, exp_busy);
    chk({tag, ".inReady_cycles"}, inrdy_cyc, exp_inrdy);
    chk({tag, ".outValid_cycles"}, outv_cyc, exp_outv);
    chk({tag, ".memWrite_cycles"}, memw_cyc, 2 * Count);
    chk({tag, ".sliceCntEn_cycles"}, scen_cyc, 3 * Count);
    chk({tag, ".regShfR_cycles"}, shf_cyc, 25 * Count);
    chk({tag, ".PDParLd_cycles"}, par_cyc, Count);
    chk({tag, ".xorSrc_shift_cycles"}, xor_cyc, 25);
    chk({tag, ".colRegShR_cycles"}, colsh_cyc, 5 * Count);
    chk({tag, ".invariant_violations"}, viol, 0);
    chk({tag, ".sequence_errors"}, seq_err, 0);
    chk({tag, ".slices_computed"}, comp_done, Count);
    step();
    chk({tag, ".done_one_cycle"}, {31'd0, done}, 0);
    chk({tag, ".idle_after"}, {31'd0, busy}, 0);
  endtask

  function automatic logic [21:0] all_outs();
    return {inReady, outValid, busy, done, adrSrc, regSrc, sliceCntEn, sliceCntClr, memRead,
            memWrite, regLd, regClr, regShfR, xorSrc, matCntEn, matCntClr, colCntEn,
            colCntClr, colRegShR, colRegClr, PDParLd, PDParClr};
  endfunction

  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; inValid = 1'b0; outReady = 1'b0;
    clear_stats();
    step();
    step();
    rst = 1'b0;
    chk("reset.outputs_zero", {10'd0, all_outs()}, 0);
    step();
    chk("reset.idle_holds", {10'd0, all_outs()}, 0);

    // Reset while shifting: abort to IDLE with every output low.
    start = 1'b1; inValid = 1'b1; outReady = 1'b1;
    step();
    start = 1'b0;
    guard = 0;
    while (!regShfR && guard < 1000) begin
      step();
      guard++;
    end
    chk("t1.reached_shift", {31'd0, regShfR}, 1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t1.outputs_zero", {10'd0, all_outs()}, 0);
    step();
    chk("t1.no_done_after_abort", {31'd0, done}, 0);

    run(-1, 0, -1, 0, -1);
    check_run("t2_full", 1986, Count, Count);
    run(5, 10, -1, 0, -1);
    check_run("t3_in_stall", 1996, Count + 10, Count);
    run(-1, 0, 30, 7, -1);
    check_run("t4_out_stall", 1993, Count, Count + 7);
    run(-1, 0, -1, 0, 500);
    check_run("t6_start_busy", 1986, Count, Count);
    run(-1, 0, -1, 0, -1);
    check_run("t6_second_run", 1986, Count, Count);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
